// File: rtl/udma_pkg.sv
// ============================================================================
// Module      : udma_pkg
// Description : Register map, CTRL bit index and watchdog state encoding for
//               hyper_evt_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package udma_pkg;

  localparam logic [4:0] c_addr_pending = 5'h00;
  localparam logic [4:0] c_addr_mask    = 5'h01;
  localparam logic [4:0] c_addr_ctrl    = 5'h02;
  localparam logic [4:0] c_addr_count   = 5'h03;
  localparam logic [4:0] c_addr_timeout = 5'h04;

  localparam int c_ctrl_irq_mode = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_EXPIRED = 2'd2
  } evt_state_e;

endpackage

`default_nettype wire

// File: rtl/hyper_evt_ctrl_if.sv
// ============================================================================
// Module      : hyper_evt_ctrl_if
// Description : Single-cycle configuration bus between the host and
//               hyper_evt_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hyper_evt_ctrl_if;
  logic [31:0] cfg_data_i;
  logic [4:0]  cfg_addr_i;
  logic        cfg_valid_i;
  logic        cfg_rwn_i;
  logic [31:0] cfg_data_o;
  logic        cfg_ready_o;

  modport master (
    output cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
    input  cfg_data_o, cfg_ready_o
  );

  modport slave (
    input  cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
    output cfg_data_o, cfg_ready_o
  );
endinterface

`default_nettype wire

// File: rtl/hyper_evt_timeout.sv
// ============================================================================
// Module      : hyper_evt_timeout
// Description : Transfer watchdog; flags a timeout when a channel transfer
//               runs TIMEOUT cycles without an end-of-transfer event.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hyper_evt_timeout
  import udma_pkg::*;
(
  input  logic        sys_clk_i,
  input  logic        rstn_i,
  input  logic [3:0]  evt_i,
  input  logic [15:0] timeout_i,
  input  logic        flag_clr_i,
  output logic        expire_o
);

  evt_state_e  r_state, w_state_next;
  logic [15:0] r_cyc_cnt, w_cyc_cnt_next;
  logic        w_start, w_eot;

  assign w_start = evt_i[0] | evt_i[1];
  assign w_eot   = evt_i[2] | evt_i[3];

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= ST_IDLE;
      r_cyc_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cyc_cnt <= w_cyc_cnt_next;
    end
  end

  // A zero TIMEOUT disables expiry; EOT is checked first so it wins a tie.
  always_comb begin
    w_state_next   = r_state;
    w_cyc_cnt_next = r_cyc_cnt;
    expire_o       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next   = ST_BUSY;
          w_cyc_cnt_next = '0;
        end
      end
      ST_BUSY: begin
        if (w_eot) begin
          w_state_next = ST_IDLE;
        end else if ((timeout_i != '0) && (r_cyc_cnt == timeout_i)) begin
          w_state_next = ST_EXPIRED;
          expire_o     = 1'b1;
        end else begin
          w_cyc_cnt_next = r_cyc_cnt + 16'd1;
        end
      end
      ST_EXPIRED: begin
        if (w_eot || flag_clr_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hyper_evt_ctrl.sv
// ============================================================================
// Module      : hyper_evt_ctrl
// Description : Event pending/mask/counter block with interrupt generation for
//               the hyper macro. Optional watchdog: HYPER_EVT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hyper_evt_ctrl
  import udma_pkg::*;
#(
  parameter int NB_EVT    = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic              sys_clk_i,
  input  logic              rstn_i,
  input  logic [NB_EVT-1:0] evt_i,
  hyper_evt_ctrl_if.slave   cfg,
  output logic              irq_o
);

  localparam int c_cnt_bits = NB_EVT * CNT_WIDTH;

  logic              w_wr, w_wr_pend, w_wr_mask, w_wr_ctrl, w_wr_cnt;
  logic [NB_EVT:0]   r_pending, r_mask, w_set, w_clr, w_pend_next;
  logic              r_irq_mode, r_irq, w_irq_next;
  logic              w_expire;
  logic [15:0]       w_timeout;
  logic [c_cnt_bits-1:0] w_cnt_flat;
  logic [31:0]       w_count32, w_rdata;
  logic              w_unused;

  assign w_wr      = cfg.cfg_valid_i & ~cfg.cfg_rwn_i;
  assign w_wr_pend = w_wr & (cfg.cfg_addr_i == c_addr_pending);
  assign w_wr_mask = w_wr & (cfg.cfg_addr_i == c_addr_mask);
  assign w_wr_ctrl = w_wr & (cfg.cfg_addr_i == c_addr_ctrl);
  assign w_wr_cnt  = w_wr & (cfg.cfg_addr_i == c_addr_count);
  assign w_unused  = &{1'b0, cfg.cfg_data_i};

  // Set after clear so a coincident event beats its W1C.
  assign w_clr       = w_wr_pend ? cfg.cfg_data_i[NB_EVT:0] : '0;
  assign w_set       = {w_expire, evt_i};
  assign w_pend_next = (r_pending & ~w_clr) | w_set;
  assign w_irq_next  = r_irq_mode ? |(w_set & r_mask) : |(w_pend_next & r_mask);

`ifdef HYPER_EVT_TIMEOUT_EN
  logic [15:0] r_timeout;

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_timeout <= 16'hFFFF;
    end else if (w_wr && (cfg.cfg_addr_i == c_addr_timeout)) begin
      r_timeout <= cfg.cfg_data_i[15:0];
    end
  end
  assign w_timeout = r_timeout;

  hyper_evt_timeout u_timeout (
    .sys_clk_i  (sys_clk_i),
    .rstn_i     (rstn_i),
    .evt_i      (evt_i[3:0]),
    .timeout_i  (r_timeout),
    .flag_clr_i (w_clr[NB_EVT]),
    .expire_o   (w_expire)
  );
`else
  assign w_timeout = '0;
  assign w_expire  = 1'b0;
`endif

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pending  <= '0;
      r_mask     <= '0;
      r_irq_mode <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_pending <= w_pend_next;
      r_irq     <= w_irq_next;
      if (w_wr_mask) r_mask     <= cfg.cfg_data_i[NB_EVT:0];
      if (w_wr_ctrl) r_irq_mode <= cfg.cfg_data_i[c_ctrl_irq_mode];
    end
  end

  for (genvar k = 0; k < NB_EVT; k++) begin : g_cnt
    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_cnt <= '0;
      end else if (w_wr_cnt) begin
        r_cnt <= evt_i[k] ? CNT_WIDTH'(1) : '0;
      end else if (evt_i[k] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
    assign w_cnt_flat[k*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
  end

  if (c_cnt_bits >= 32) begin : g_cnt_wide
    assign w_count32 = w_cnt_flat[31:0];
  end else begin : g_cnt_narrow
    assign w_count32 = {{(32-c_cnt_bits){1'b0}}, w_cnt_flat};
  end

  always_comb begin
    w_rdata = '0;
    case (cfg.cfg_addr_i)
      c_addr_pending: w_rdata[NB_EVT:0]      = r_pending;
      c_addr_mask:    w_rdata[NB_EVT:0]      = r_mask;
      c_addr_ctrl:    w_rdata[c_ctrl_irq_mode] = r_irq_mode;
      c_addr_count:   w_rdata                = w_count32;
      c_addr_timeout: w_rdata[15:0]          = w_timeout;
      default:        w_rdata                = '0;
    endcase
  end

  assign cfg.cfg_data_o  = w_rdata;
  assign cfg.cfg_ready_o = 1'b1;
  assign irq_o           = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_hyper_evt_ctrl.sv
// ============================================================================
// Module      : tb_hyper_evt_ctrl
// Description : Self-checking bench for hyper_evt_ctrl against a cycle-level
//               reference model; HYPER_EVT_TIMEOUT_EN selects watchdog tests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hyper_evt_ctrl;
  import udma_pkg::*;

  logic       sys_clk = 1'b0;
  logic       rstn    = 1'b0;
  logic [3:0] evt     = 4'h0;
  logic       irq;

  hyper_evt_ctrl_if bus ();

  hyper_evt_ctrl #(.NB_EVT(4), .CNT_WIDTH(8)) dut (
    .sys_clk_i (sys_clk),
    .rstn_i    (rstn),
    .evt_i     (evt),
    .cfg       (bus),
    .irq_o     (irq)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [4:0] m_pend, m_mask;
  bit         m_mode, m_irq;
  int         m_cnt [4];
  int         m_timeout, m_phase, m_elapsed;

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_mode = 1'b0; m_irq = 1'b0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    m_timeout = 65535; m_phase = 0; m_elapsed = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      5'd0: v = {27'b0, m_pend};
      5'd1: v = {27'b0, m_mask};
      5'd2: v = {31'b0, m_mode};
      5'd3: for (int k = 0; k < 4; k++) v = v | (32'(m_cnt[k]) << (8 * k));
`ifdef HYPER_EVT_TIMEOUT_EN
      5'd4: v = 32'(m_timeout);
`endif
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_update(input logic [3:0] e, input bit v, input bit r,
                              input logic [4:0] a, input logic [31:0] d);
    bit         wr;
    bit         expire;
    logic [4:0] set, clr, nxt;
    wr     = v && !r;
    expire = 1'b0;
    clr    = (wr && a == 5'd0) ? d[4:0] : 5'd0;
`ifdef HYPER_EVT_TIMEOUT_EN
    if (m_phase == 0) begin
      if (e[0] || e[1]) begin m_phase = 1; m_elapsed = 0; end
    end else if (m_phase == 1) begin
      if (e[2] || e[3]) m_phase = 0;
      else if (m_timeout != 0 && m_elapsed == m_timeout) begin m_phase = 2; expire = 1'b1; end
      else m_elapsed = (m_elapsed + 1) % 65536;
    end else begin
      if (e[2] || e[3] || clr[4]) m_phase = 0;
    end
`endif
    set   = {expire, e};
    nxt   = (m_pend & ~clr) | set;
    m_irq = m_mode ? |(set & m_mask) : |(nxt & m_mask);
    for (int k = 0; k < 4; k++) begin
      if (wr && a == 5'd3) m_cnt[k] = e[k] ? 1 : 0;
      else if (e[k] && m_cnt[k] < 255) m_cnt[k]++;
    end
    if (wr && a == 5'd1) m_mask = d[4:0];
    if (wr && a == 5'd2) m_mode = d[0];
`ifdef HYPER_EVT_TIMEOUT_EN
    if (wr && a == 5'd4) m_timeout = int'(d[15:0]);
`endif
    m_pend = nxt;
  endtask

  // One bus cycle; entered and left just after a falling edge.
  task automatic cycle(input logic [3:0] e, input bit v, input bit r,
                       input logic [4:0] a, input logic [31:0] d, output logic [31:0] rd);
    evt = e;
    bus.cfg_valid_i = v; bus.cfg_rwn_i = r; bus.cfg_addr_i = a; bus.cfg_data_i = d;
    #1;
    rd = bus.cfg_data_o;
    check_eq("rdata", rd, model_read(a));
    check_eq("ready", 32'(bus.cfg_ready_o), 32'd1);
    @(posedge sys_clk);
    model_update(e, v, r, a, d);
    @(negedge sys_clk);
    check_eq("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic idle(input int n);
    logic [31:0] d;
    for (int i = 0; i < n; i++) cycle(4'h0, 1'b0, 1'b1, 5'd0, 32'h0, d);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    logic [31:0] d;
    cycle(4'h0, 1'b1, 1'b0, a, v, d);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    cycle(4'h0, 1'b1, 1'b1, a, 32'h0, v);
  endtask

  task automatic pulse(input logic [3:0] e);
    logic [31:0] d;
    cycle(e, 1'b0, 1'b1, 5'd0, 32'h0, d);
  endtask

  task automatic do_reset();
    logic [31:0] d;
    bus.cfg_valid_i = 1'b0; bus.cfg_addr_i = 5'd0;
    #3;
    rstn = 1'b0;
    evt  = 4'hF;
    #1;
    check_eq("rst_irq_async", 32'(irq), 32'd0);
    check_eq("rst_pend_async", bus.cfg_data_o, 32'd0);
    model_reset();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    evt  = 4'h0;
    rstn = 1'b1;
    rd(5'd0, d); check_eq("rst_pending", d, 32'h0);
    rd(5'd1, d); check_eq("rst_mask", d, 32'h0);
    rd(5'd2, d); check_eq("rst_ctrl", d, 32'h0);
    rd(5'd3, d); check_eq("rst_count", d, 32'h0);
    rd(5'd4, d);
`ifdef HYPER_EVT_TIMEOUT_EN
    check_eq("rst_timeout", d, 32'hFFFF);
    check_eq("rst_state", 32'(dut.u_timeout.r_state), 32'(ST_IDLE));
`else
    check_eq("rst_timeout", d, 32'h0);
`endif
    check_eq("rst_irq", 32'(irq), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  e;
    logic [4:0]  a;
    bit          v, r;

    bus.cfg_data_i = '0; bus.cfg_addr_i = '0; bus.cfg_valid_i = 1'b0; bus.cfg_rwn_i = 1'b1;
    model_reset();
    @(negedge sys_clk);
    do_reset();

    // Level mode pending / W1C
    wr(5'd1, 32'h04);
    pulse(4'b0100);
    check_eq("lvl_irq_set", 32'(irq), 32'd1);
    rd(5'd0, d); check_eq("lvl_pending", d, 32'h04);
    wr(5'd0, 32'h04);
    check_eq("lvl_irq_clr", 32'(irq), 32'd0);

    // Set wins over coincident W1C
    cycle(4'b0001, 1'b1, 1'b0, 5'd0, 32'h01, d);
    rd(5'd0, d); check_eq("set_prio", d, 32'h01);

    // Saturation and coincident COUNT write
    wr(5'd3, 32'h0);
    for (int i = 0; i < 300; i++) pulse(4'b0010);
    rd(5'd3, d); check_eq("cnt_sat", (d >> 8) & 32'hFF, 32'hFF);
    cycle(4'b0010, 1'b1, 1'b0, 5'd3, 32'h0, d);
    rd(5'd3, d); check_eq("cnt_load1", d, 32'h0000_0100);

    // Pulse mode
    wr(5'd0, 32'h1F);
    wr(5'd1, 32'h0F);
    wr(5'd2, 32'h01);
    pulse(4'b0011); check_eq("pls_first", 32'(irq), 32'd1);
    idle(1);        check_eq("pls_first_end", 32'(irq), 32'd0);
    pulse(4'b0011); check_eq("pls_repeat", 32'(irq), 32'd1);
    idle(1);        check_eq("pls_repeat_end", 32'(irq), 32'd0);
    wr(5'd2, 32'h00);

`ifdef HYPER_EVT_TIMEOUT_EN
    pulse(4'b1000);
    wr(5'd1, 32'h10);
    wr(5'd0, 32'h1F);
    wr(5'd4, 32'd10);
    pulse(4'b0010);
    idle(10);
    rd(5'd0, d); check_eq("tmo_before", d & 32'h10, 32'h0);
    rd(5'd0, d); check_eq("tmo_flag", d & 32'h10, 32'h10);
    check_eq("tmo_state", 32'(dut.u_timeout.r_state), 32'(ST_EXPIRED));
    wr(5'd0, 32'h10);
    check_eq("tmo_w1c_state", 32'(dut.u_timeout.r_state), 32'(ST_IDLE));
    wr(5'd4, 32'd0);
    pulse(4'b0010);
    idle(70000);
    rd(5'd0, d); check_eq("tmo_zero", d & 32'h10, 32'h0);
    check_eq("tmo_zero_state", 32'(dut.u_timeout.r_state), 32'(ST_BUSY));
    pulse(4'b0100);
`else
    wr(5'd4, 32'd10);
    rd(5'd4, d); check_eq("tmo_absent", d, 32'h0);
    wr(5'd1, 32'h1F);
    rd(5'd1, d); check_eq("mask_all", d, 32'h1F);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      e = 4'h0;
      for (int k = 0; k < 4; k++) e[k] = ($urandom_range(0, 3) == 0);
      v = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 1) == 1;
      a = 5'($urandom_range(0, 7));
      d = $urandom;
      if (a == 5'd4) d = 32'($urandom_range(0, 40));
      cycle(e, v, r, a, d, d);
    end

    // Reset mid-transfer with pending bits
    idle(1);
    pulse(4'b0011);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hyper_evt_ctrl.md
HYPER_EVT_CTRL -- requirements
Module: hyper_evt_ctrl

Interface
REQ-001 SHALL have parameter NB_EVT, default 4, number of event inputs from the hyper macro.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of each per-event counter.
REQ-003 SHALL have port sys_clk_i, input, 1, the single clock for all logic.
REQ-004 SHALL have port rstn_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port evt_i, input, NB_EVT, one-cycle event pulses: [0] rx channel, [1] tx channel, [2] read EOT, [3] write EOT.
REQ-006 SHALL have port cfg_data_i, input, 32, register write data.
REQ-007 SHALL have port cfg_addr_i, input, 5, word address.
REQ-008 SHALL have port cfg_valid_i, input, 1, access strobe.
REQ-009 SHALL have port cfg_rwn_i, input, 1, 1 = read, 0 = write.
REQ-010 SHALL have port cfg_data_o, output, 32, read data.
REQ-011 SHALL have port cfg_ready_o, output, 1, access accepted.
REQ-012 SHALL have port irq_o, output, 1, interrupt to the event unit.

Function
REQ-013 SHALL tie cfg_ready_o high, with every access completing in the cycle cfg_valid_i is high.
REQ-014 SHALL drive cfg_data_o combinationally from the addressed register, reading unmapped addresses as 0.
REQ-015 SHALL implement the register map:
- 0x00 PENDING: bits [NB_EVT:0], read/W1C.
- 0x01 MASK: bits [NB_EVT:0], RW, 1 = enabled.
- 0x02 CTRL: bit0 irq_mode (0 level, 1 pulse), RW.
- 0x03 COUNT: counters packed with cnt0 at LSB, read-only; any write clears all counters.
- 0x04 TIMEOUT: bits [15:0], RW.
REQ-016 SHALL set PENDING[k] in the cycle after evt_i[k] is high.
REQ-017 SHALL give set priority when an event and a W1C hit the same PENDING bit in the same cycle, leaving the bit at 1.
REQ-018 SHALL increment cnt[k] on each evt_i[k], saturating at 2^CNT_WIDTH-1 with no wrap.
REQ-019 SHALL load cnt[k] with 1 when evt_i[k] coincides with a COUNT write, otherwise 0 on a COUNT write.
REQ-020 SHALL drive irq_o from a register, updated one cycle after the causing event or register write.
REQ-021 SHALL, in level mode, drive irq_o = OR(PENDING_next & MASK).
REQ-022 SHALL, in pulse mode, drive irq_o as a one-cycle pulse for each cycle containing a newly set masked bit, including the timeout bit.
REQ-023 SHALL have a MASK or CTRL write take effect from the next cycle's irq_o computation.

Reset
REQ-024 SHALL, on rstn_i low, asynchronously clear PENDING, MASK, CTRL and all counters, set TIMEOUT to 0xFFFF, put the FSM in IDLE, and drive irq_o=0 and cfg_data_o=0 for address 0.
REQ-025 SHALL discard an event pulse arriving during reset, with no pending bit or count resulting after release.

Configuration
REQ-026 SHALL compile the timeout watchdog in only when HYPER_EVT_TIMEOUT_EN is defined.
REQ-027 SHALL, with HYPER_EVT_TIMEOUT_EN defined, run a 3-state FSM:
- IDLE -> BUSY on evt_i[0] or evt_i[1].
- BUSY -> IDLE on evt_i[2] or evt_i[3]; EOT wins over a simultaneous timeout.
- BUSY -> EXPIRED when the 16-bit cycle counter equals TIMEOUT, setting PENDING[NB_EVT].
- EXPIRED -> IDLE on an EOT event or a W1C of PENDING[NB_EVT].
REQ-028 SHALL clear the cycle counter on entry to BUSY, hold it elsewhere, and never reach EXPIRED when TIMEOUT=0.
REQ-029 SHALL, without HYPER_EVT_TIMEOUT_EN, read PENDING[NB_EVT] and TIMEOUT as 0, ignore writes to them, and omit the FSM and counter.

Structure
REQ-030 SHALL place the register address constants, the CTRL bit index and the FSM state enum in udma_pkg.
REQ-031 SHALL implement the watchdog as the sub-module hyper_evt_timeout, instantiated under the macro.

Verification
REQ-032 SHALL cover: evt_i=4'b0100 once with MASK=0x04 in level mode -> PENDING=0x04 and irq_o=1 next cycle; W1C 0x04 -> irq_o=0 one cycle later.
REQ-033 SHALL cover: 300 pulses on evt_i[1] -> COUNT[15:8]=0xFF with no wrap; a COUNT write coincident with evt_i[1] -> cnt1=1.
REQ-034 SHALL cover: evt_i[0] and a W1C of bit 0 in the same cycle -> PENDING[0]=1.
REQ-035 SHALL cover: pulse mode, MASK=0x0F, evt_i=4'b0011 -> a single one-cycle irq_o pulse; a repeat with bits already pending -> another pulse.
REQ-036 SHALL cover, with the macro: TIMEOUT=10, evt_i[1], then no EOT -> PENDING[4]=1 after 11 cycles and FSM EXPIRED; with TIMEOUT=0 and no EOT -> no flag after 70000 cycles.
REQ-037 SHALL cover: rstn_i asserted mid-BUSY with pending bits set -> all registers at reset values, irq_o=0 and TIMEOUT=0xFFFF after release.
